// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell, one operand bit per clock,
// LSB first, with a start/busy/done handshake.
module serial_addsub #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [CNT_W-1:0] cnt;
    logic             c;
    logic             sum_bit;
    logic             carry_nxt;
    logic             last_bit;

    // The single full-adder cell
    assign sum_bit   = sa[0] ^ sb[0] ^ c;
    assign carry_nxt = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
    assign last_bit  = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            cnt   <= '0;
            c     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction as a + ~b + 1: invert b, seed carry with 1
                        sa    <= a;
                        sb    <= sub ? ~b : b;
                        c     <= sub;
                        cnt   <= '0;
                        sr    <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sr  <= {sum_bit, sr[WIDTH-1:1]};
                    c   <= carry_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        // c still holds the carry into the MSB here
                        s     <= {sum_bit, sr[WIDTH-1:1]};
                        cout  <= carry_nxt;
                        ovf   <= c ^ carry_nxt;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Randomized self-checking bench for serial_addsub (WIDTH=8) against an
// integer-arithmetic reference model.
module tb_serial_addsub;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    int total;
    int bad;

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sub  (sub),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .s    (s),
        .cout (cout),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on unsigned and signed views
    function automatic void ref_model(input logic [7:0] ra, input logic [7:0] rb, input logic rsub,
                                      output logic [7:0] rs, output logic rc, output logic ro);
        int ua, ub, r, sa_i, sb_i, sr_i;
        ua = int'(ra);
        ub = int'(rb);
        sa_i = int'($signed(ra));
        sb_i = int'($signed(rb));
        r    = rsub ? ua - ub : ua + ub;
        sr_i = rsub ? sa_i - sb_i : sa_i + sb_i;
        rs   = 8'(r);
        rc   = rsub ? (ua >= ub) : (r > 255);
        ro   = (sr_i > 127) || (sr_i < -128);
    endfunction

    // Issues one operation, scrambles the inputs after acceptance, and reports
    // latency, busy cycles and final outputs (lat = -1 on timeout).
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tsub,
                          output int lat, output int busy_cyc,
                          output logic [7:0] rs, output logic rc, output logic ro);
        @(negedge clk);
        a = ta; b = tb_; sub = tsub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
        lat = 0;
        busy_cyc = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cyc++;
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
        rs = s; rc = cout; ro = ovf;
    endtask

    task automatic check_op(input string name, input logic [7:0] ta, input logic [7:0] tb_, input logic tsub);
        int lat, bc;
        logic [7:0] rs, es;
        logic rc, ro, ec, eo;
        ref_model(ta, tb_, tsub, es, ec, eo);
        run_op(ta, tb_, tsub, lat, bc, rs, rc, ro);
        total++;
        if (lat !== 8) begin bad++; $display("FAIL %s latency got=%0d exp=8", name, lat); end
        total++;
        if (bc !== 8) begin bad++; $display("FAIL %s busy_cycles got=%0d exp=8", name, bc); end
        total++;
        if ({rs, rc, ro} !== {es, ec, eo})
            begin bad++; $display("FAIL %s a=%h b=%h sub=%0d got s=%h c=%0d v=%0d exp s=%h c=%0d v=%0d",
                                  name, ta, tb_, tsub, rs, rc, ro, es, ec, eo); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, done, s, cout, ovf} !== 12'h000)
            begin bad++; $display("FAIL reset_state got busy=%0d done=%0d s=%h c=%0d v=%0d exp all 0",
                                  busy, done, s, cout, ovf); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        check_op("add_3c_0f", 8'h3C, 8'h0F, 1'b0);
        check_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
        check_op("add_7f_01", 8'h7F, 8'h01, 1'b0);
        check_op("add_80_80", 8'h80, 8'h80, 1'b0);
        for (int i = 0; i < 15; i++) check_op("add_rand", 8'($urandom), 8'($urandom), 1'b0);
    endtask

    task automatic test_sub();
        check_op("sub_05_07", 8'h05, 8'h07, 1'b1);
        check_op("sub_80_01", 8'h80, 8'h01, 1'b1);
        check_op("sub_00_00", 8'h00, 8'h00, 1'b1);
        check_op("sub_7f_ff", 8'h7F, 8'hFF, 1'b1);
        for (int i = 0; i < 15; i++) check_op("sub_rand", 8'($urandom), 8'($urandom), 1'b1);
    endtask

    task automatic test_ignore_start();
        int dones, edges;
        logic [7:0] es, rs;
        logic ec, eo, rc, ro;
        ref_model(8'h5A, 8'h33, 1'b0, es, ec, eo);
        @(negedge clk);
        a = 8'h5A; b = 8'h33; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        dones = 0;
        rs = '0; rc = 1'b0; ro = 1'b0;
        for (edges = 1; edges <= 16; edges++) begin
            @(negedge clk);
            start = (edges == 2 || edges == 5);
            a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
            if (done) begin dones++; rs = s; rc = cout; ro = ovf; end
        end
        start = 1'b0;
        total++;
        if (dones !== 1) begin bad++; $display("FAIL ignore_start done_pulses got=%0d exp=1", dones); end
        total++;
        if ({rs, rc, ro} !== {es, ec, eo})
            begin bad++; $display("FAIL ignore_start result got s=%h c=%0d v=%0d exp s=%h c=%0d v=%0d",
                                  rs, rc, ro, es, ec, eo); end
    endtask

    task automatic test_back_to_back();
        int cyc, t1, t2;
        logic [7:0] e1, e2, r1, r2;
        logic ec, eo;
        ref_model(8'hC3, 8'h21, 1'b1, e1, ec, eo);
        ref_model(8'h10, 8'h20, 1'b0, e2, ec, eo);
        @(negedge clk);
        a = 8'hC3; b = 8'h21; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        a = 8'h10; b = 8'h20; sub = 1'b0;
        cyc = 0; t1 = -1; t2 = -1; r1 = '0; r2 = '0;
        while (t2 < 0 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (done && t1 < 0) begin
                t1 = cyc; r1 = s;
            end else if (done) begin
                t2 = cyc; r2 = s;
            end else if (t1 >= 0) begin
                start = 1'b0;
                total++;
                if (s !== r1) begin bad++; $display("FAIL b2b_hold cyc=%0d got s=%h exp=%h", cyc, s, r1); end
            end
        end
        start = 1'b0;
        total++;
        if (t1 !== 8) begin bad++; $display("FAIL b2b_first_done cyc got=%0d exp=8", t1); end
        total++;
        if (t2 - t1 !== 9) begin bad++; $display("FAIL b2b_spacing got=%0d exp=9", t2 - t1); end
        total++;
        if (r1 !== e1) begin bad++; $display("FAIL b2b_first_s got=%h exp=%h", r1, e1); end
        total++;
        if (r2 !== e2) begin bad++; $display("FAIL b2b_second_s got=%h exp=%h", r2, e2); end
        @(posedge clk); #1;
        total++;
        if ({busy, done} !== 2'b00) begin bad++; $display("FAIL b2b_idle got busy=%0d done=%0d exp 0 0", busy, done); end
    endtask

    task automatic test_reset_mid();
        int dones, lat, bc;
        logic [7:0] rs;
        logic rc, ro;
        // Leave non-zero outputs behind so the clear is observable
        check_op("pre_reset", 8'hFF, 8'h81, 1'b0);
        @(negedge clk);
        a = 8'h55; b = 8'h66; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, s, cout, ovf} !== 12'h000)
            begin bad++; $display("FAIL async_reset got busy=%0d done=%0d s=%h c=%0d v=%0d exp all 0",
                                  busy, done, s, cout, ovf); end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        total++;
        if (dones !== 0) begin bad++; $display("FAIL reset_abort activity_cycles got=%0d exp=0", dones); end
        run_op(8'h01, 8'h01, 1'b0, lat, bc, rs, rc, ro);
        total++;
        if ({lat, rs, rc, ro} !== {32'd8, 8'h02, 1'b0, 1'b0})
            begin bad++; $display("FAIL post_reset_op got lat=%0d s=%h c=%0d v=%0d exp lat=8 s=02 c=0 v=0",
                                  lat, rs, rc, ro); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_add();
        test_sub();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
